weight_mem_rsp: RTL and testbench
=================================

Name: weight_mem_rsp

Overview:
- Responder end of the BIU-to-arbiter read protocol.
- Accepts word-read requests (addr/vld/req, rdy back), reads a single-port weight SRAM with 1-cycle read latency, and returns addr/data/vld responses with rdy backpressure.
- Sits between the arbiter grant path and the on-chip weight SRAM.
- Bounds outstanding reads with a small response FIFO so no data is lost under backpressure.

Parameters:
- MEM_BASE, 32'h0000_0000, byte base address of the SRAM window.
- MEM_AW, 12, SRAM word-address width; window size is 4*2^MEM_AW bytes.
- FIFO_DEPTH, 4, response FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_addr  in  32  byte address of the requested word
- req_vld  in  1  request valid
- req_req  in  1  requester session active (bus ownership)
- req_rdy  out  1  request accepted when high with req_vld&req_req
- rsp_addr  out  32  byte address echoed with the response
- rsp_data  out  32  read data
- rsp_err  out  1  response is an error (out-of-range or misaligned)
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  consumer ready
- sram_cen  out  1  SRAM read enable, active high
- sram_addr  out  MEM_AW  SRAM word address
- sram_rdata  in  32  SRAM data, valid the cycle after sram_cen
- busy  out  1  session active or responses pending
- err_cnt  out  8  saturating count of error responses issued

Behaviour:
- Reset: asynchronous, active-low. Clocked on posedge clk.
  - All outputs 0 at reset: req_rdy, rsp_vld, rsp_err, sram_cen, busy; err_cnt=0; rsp_addr/rsp_data=0.
  - FIFO empty; in-flight flag 0; state IDLE.
- Definitions:
  - pending = fifo_count + inflight, where inflight = 1 if a read was accepted last cycle.
  - accept = req_req & req_vld & req_rdy.
- req_rdy (combinational) = (state==ACTIVE) & req_req & (pending < FIFO_DEPTH).
  - Requester must hold addr/vld stable until accepted.
- Address decode:
  - off = req_addr - MEM_BASE.
  - Error if req_addr[1:0]!=0 or off >= 4*2^MEM_AW (unsigned; addresses below MEM_BASE wrap large, so they also error).
  - Valid: sram_cen=accept, sram_addr=off[MEM_AW+1:2] in the same cycle.
  - Error: no SRAM access; entry carries data 32'h0, err=1.
- Pipeline:
  - Accept in cycle N.
  - Cycle N+1: sram_rdata (or the 0/err value) pushed into the FIFO with the registered address.
  - Cycle N+2: rsp_vld. Latency is 2 cycles with rsp_rdy high; throughput is 1 response/cycle.
- Response handshake:
  - rsp_vld = FIFO non-empty; rsp_addr/data/err come from the FIFO head.
  - Pop on rsp_vld & rsp_rdy. While rsp_rdy=0, head outputs stay stable.
  - Simultaneous push and pop in one cycle keeps the count unchanged.
  - The credit check guarantees a push never meets a full FIFO; an overflow is a design error (assertion in bench).
- err_cnt: +1 on each popped entry with err=1; saturates at 8'hFF.
- FSM:
  - IDLE -> ACTIVE when req_req=1.
  - ACTIVE -> DRAIN when req_req=0 and pending!=0.
  - ACTIVE -> IDLE when req_req=0 and pending==0.
  - DRAIN -> IDLE when pending==0. No accepts in DRAIN, even if req_req rises again; re-entry goes through IDLE (one-cycle gap).
  - busy = state!=IDLE.
- req_req falling in the same cycle as req_vld: not accepted (req_rdy needs req_req).
- Reset mid-operation: in-flight and queued responses are discarded, no rsp_vld afterwards; SRAM contents untouched.
- Widths: the subtraction is 32-bit unsigned; counters are log2(FIFO_DEPTH)+1 bits.

Test Plan:
- Single read:
  - Stimulus: SRAM word 5 = 32'hA5A5_0005; request req_addr = MEM_BASE+0x14, rsp_rdy=1.
  - Response: sram_cen and sram_addr=5 in the accept cycle; 2 cycles later rsp_vld=1, rsp_addr=0x14, rsp_data=32'hA5A5_0005, rsp_err=0.
- 72-word burst:
  - Stimulus: data[i]=i; req_vld held high, rsp_rdy=1.
  - Response: 72 accepts in 72 consecutive cycles, responses in order, data 0..71, last response at cycle 73.
- Backpressure:
  - Stimulus: rsp_rdy=0 during a 10-word burst.
  - Response: exactly FIFO_DEPTH(4) accepts, then req_rdy=0, head stable; after rsp_rdy=1, all 10 delivered in order with no loss or duplicates.
- Errors:
  - Stimulus: req_addr=MEM_BASE+0x4002, then MEM_BASE+0x4000 (MEM_AW=12).
  - Response: sram_cen=0 for both; both responses rsp_err=1, rsp_data=0; err_cnt=2. After 300 errors, err_cnt=255.
- Session drop:
  - Stimulus: req_req falls with 3 responses pending and rsp_rdy=0.
  - Response: state DRAIN, busy=1, req_rdy=0; after 3 pops busy=0 next cycle. req_req re-raised during DRAIN gets no accepts until after IDLE.
- Async reset mid-burst:
  - Stimulus: rst_n low between clock edges with 4 queued responses.
  - Response: rsp_vld, req_rdy and busy drop immediately; after release, no stale responses, and a new read returns correct data.

Source files
------------

// File: rtl/weight_mem_rsp_if.sv
// Request/response bus between the arbiter grant path and the weight SRAM
// responder: word-read requests in, addr/data/err responses out.
interface weight_mem_rsp_if;
   logic [31:0] req_addr;
   logic        req_vld;
   logic        req_req;
   logic        req_rdy;
   logic [31:0] rsp_addr;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        rsp_vld;
   logic        rsp_rdy;

   modport master (
      output req_addr, req_vld, req_req, rsp_rdy,
      input  req_rdy, rsp_addr, rsp_data, rsp_err, rsp_vld
   );

   modport slave (
      input  req_addr, req_vld, req_req, rsp_rdy,
      output req_rdy, rsp_addr, rsp_data, rsp_err, rsp_vld
   );
endinterface

// File: rtl/weight_mem_rsp.sv
// Weight SRAM read responder: decodes word reads, issues 1-cycle SRAM reads
// and returns responses through a credit-bounded FIFO.
module weight_mem_rsp #(
   parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
   parameter int          MEM_AW     = 12,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   weight_mem_rsp_if.slave   bus,
   output logic              sram_cen,
   output logic [MEM_AW-1:0] sram_addr,
   input  logic [31:0]       sram_rdata,
   output logic              busy,
   output logic [7:0]        err_cnt
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [32:0] WIN = 33'(4) << MEM_AW;

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

   state_e          state_q, state_d;
   logic            infl_q, infl_d;
   logic [31:0]     infl_addr_q, infl_addr_d;
   logic            infl_err_q, infl_err_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      err_cnt_q, err_cnt_d;

   logic [31:0]     addr_mem_q [FIFO_DEPTH];
   logic [31:0]     data_mem_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] err_mem_q;

   logic [31:0]     off;
   logic            dec_err;
   logic [CW:0]     pending;
   logic            req_rdy;
   logic            accept;
   logic            push;
   logic            pop;
   logic            rsp_vld;

   always_comb begin
      off     = bus.req_addr - MEM_BASE;
      dec_err = (bus.req_addr[1:0] != 2'b00) || ({1'b0, off} >= WIN);
      pending = {1'b0, count_q} + (CW+1)'(infl_q);
      req_rdy = (state_q == ACTIVE) && bus.req_req &&
                (pending < (CW+1)'(FIFO_DEPTH));
      accept  = bus.req_vld && bus.req_req && req_rdy;
      push    = infl_q;
      rsp_vld = (count_q != '0);
      pop     = rsp_vld && bus.rsp_rdy;
   end

   assign sram_cen     = accept && !dec_err;
   assign sram_addr    = off[MEM_AW+1:2];
   assign bus.req_rdy  = req_rdy;
   assign bus.rsp_vld  = rsp_vld;
   assign bus.rsp_addr = addr_mem_q[rd_ptr_q];
   assign bus.rsp_data = data_mem_q[rd_ptr_q];
   assign bus.rsp_err  = err_mem_q[rd_ptr_q];
   assign busy         = (state_q != IDLE);
   assign err_cnt      = err_cnt_q;

   always_comb begin
      state_d     = state_q;
      infl_d      = accept;
      infl_addr_d = accept ? bus.req_addr : infl_addr_q;
      infl_err_d  = accept ? dec_err : infl_err_q;
      wr_ptr_d    = wr_ptr_q + PW'(push);
      rd_ptr_d    = rd_ptr_q + PW'(pop);
      count_d     = count_q + CW'(push) - CW'(pop);
      err_cnt_d   = err_cnt_q;
      if (pop && err_mem_q[rd_ptr_q] && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'd1;
      // Leaving a session always passes through IDLE, so DRAIN ignores req_req.
      unique case (state_q)
         IDLE:    if (bus.req_req) state_d = ACTIVE;
         ACTIVE:  if (!bus.req_req) state_d = (pending != '0) ? DRAIN : IDLE;
         DRAIN:   if (pending == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         infl_q      <= 1'b0;
         infl_addr_q <= '0;
         infl_err_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         infl_q      <= infl_d;
         infl_addr_q <= infl_addr_d;
         infl_err_q  <= infl_err_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // Error entries never touched the SRAM, so their data is forced to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            addr_mem_q[i] <= '0;
            data_mem_q[i] <= '0;
         end
         err_mem_q <= '0;
      end else if (push) begin
         addr_mem_q[wr_ptr_q] <= infl_addr_q;
         data_mem_q[wr_ptr_q] <= infl_err_q ? 32'h0 : sram_rdata;
         err_mem_q[wr_ptr_q]  <= infl_err_q;
      end
   end
endmodule

// File: tb/tb_weight_mem_rsp.sv
// Bench for weight_mem_rsp: directed vectors, corner sequences and random
// traffic checked against a queue-based response model.
module tb_weight_mem_rsp;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int AW    = 12;
   localparam int DEPTH = 4;
   localparam int WORDS = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sram_cen;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_rdata;
   logic          busy;
   logic [7:0]    err_cnt;

   always #5 clk = ~clk;

   weight_mem_rsp_if bus ();

   weight_mem_rsp #(
      .MEM_BASE(BASE), .MEM_AW(AW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .sram_cen(sram_cen), .sram_addr(sram_addr),
      .sram_rdata(sram_rdata), .busy(busy), .err_cnt(err_cnt)
   );

   logic [31:0] mem [WORDS];

   always @(posedge clk)
      if (sram_cen) sram_rdata <= mem[sram_addr];

   typedef struct {
      logic [31:0] addr;
      logic        err;
      logic [31:0] data;
   } rsp_t;

   typedef rsp_t vec_t;

   rsp_t exp_q [$];
   rsp_t mon_e;
   int   chk_n = 0;
   int   pass_n = 0;
   int   acc_n = 0;
   int   pop_n = 0;
   int   mdl_err = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      chk_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Response expected for a read of address a, from the address-window rules.
   function automatic rsp_t model(input logic [31:0] a);
      rsp_t r;
      logic [31:0] o;
      o = a - BASE;
      r.addr = a;
      r.err  = (a % 4 != 0) || (o >= 32'(4 * WORDS));
      r.data = 32'h0;
      if (!r.err) r.data = mem[o / 4];
      return r;
   endfunction

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (bus.req_vld && bus.req_req && bus.req_rdy) begin
            exp_q.push_back(model(bus.req_addr));
            acc_n++;
            chk("credit_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
         end
         if (bus.rsp_vld && bus.rsp_rdy) begin
            pop_n++;
            if (exp_q.size() == 0) begin
               chk("spurious_rsp", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("sb_addr", bus.rsp_addr, mon_e.addr);
               chk("sb_data", bus.rsp_data, mon_e.data);
               chk("sb_err", 32'(bus.rsp_err), 32'(mon_e.err));
               if (mon_e.err && mdl_err < 255) mdl_err++;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      bus.rsp_rdy = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if (exp_q.size() == 0 && !bus.rsp_vld) break;
         cyc();
      end
      chk("drain_done", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_read(input vec_t v);
      int k;
      bus.req_req  = 1'b1;
      bus.rsp_rdy  = 1'b1;
      bus.req_addr = v.addr;
      bus.req_vld  = 1'b1;
      #1;
      k = 0;
      while (!bus.req_rdy && k < 10) begin
         cyc();
         k++;
      end
      chk("rd_rdy", 32'(bus.req_rdy), 32'd1);
      chk("rd_cen", 32'(sram_cen), 32'(!v.err));
      if (!v.err) chk("rd_sram_addr", 32'(sram_addr), (v.addr - BASE) >> 2);
      cyc();
      bus.req_vld = 1'b0;
      cyc();
      chk("rd_vld", 32'(bus.rsp_vld), 32'd1);
      chk("rd_addr", bus.rsp_addr, v.addr);
      chk("rd_data", bus.rsp_data, v.data);
      chk("rd_err", 32'(bus.rsp_err), 32'(v.err));
      cyc();
   endtask

   // Streams reads at consecutive words from base a until n are accepted.
   task automatic burst(input logic [31:0] a, input int n, output int cycles);
      int got;
      got = 0;
      cycles = 0;
      bus.req_vld = 1'b1;
      while (got < n && cycles < 3000) begin
         bus.req_addr = a + 32'(4 * got);
         #1;
         if (bus.req_rdy) got++;
         cyc();
         cycles++;
      end
      bus.req_vld = 1'b0;
      chk("burst_all_accepted", 32'(got), 32'(n));
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 9))
         0:       a = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 255));
         1:       a = BASE + 32'(4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3));
         2:       a = BASE - 32'(4 * $urandom_range(1, 16));
         default: a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
      endcase
      return a;
   endfunction

   vec_t vecs [7];
   int   n, c, k, a0, p0;
   logic took;
   logic seen;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = {16'hA5A5, 16'(i)};
      vecs[0] = '{BASE + 32'h14,        1'b0, 32'hA5A5_0005};
      vecs[1] = '{BASE + 32'h0,         1'b0, 32'hA5A5_0000};
      vecs[2] = '{BASE + 32'h3FFC,      1'b0, 32'hA5A5_0FFF};
      vecs[3] = '{BASE + 32'h4002,      1'b1, 32'h0};
      vecs[4] = '{BASE + 32'h4000,      1'b1, 32'h0};
      vecs[5] = '{BASE + 32'h1,         1'b1, 32'h0};
      vecs[6] = '{BASE - 32'h4,         1'b1, 32'h0};

      rst_n        = 1'b0;
      bus.req_addr = '0;
      bus.req_vld  = 1'b0;
      bus.req_req  = 1'b0;
      bus.rsp_rdy  = 1'b0;
      #2;
      chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
      chk("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_rsp_addr", bus.rsp_addr, 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      chk("rst_sram_cen", 32'(sram_cen), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      cyc();
      cyc();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      cyc();

      for (int i = 0; i < 7; i++) do_read(vecs[i]);
      chk("table_err_cnt", 32'(err_cnt), 32'd4);

      // 72-word burst, one accept per cycle, last response two cycles on
      wait_drain();
      for (int i = 0; i < 72; i++) mem[i] = 32'(i);
      burst(BASE, 72, c);
      chk("burst_cycles", 32'(c), 32'd72);
      cyc();
      chk("burst_last_vld", 32'(bus.rsp_vld), 32'd1);
      chk("burst_last_data", bus.rsp_data, 32'd71);
      cyc();
      chk("burst_after_vld", 32'(bus.rsp_vld), 32'd0);

      // backpressure: only DEPTH accepts, head frozen
      wait_drain();
      p0 = pop_n;
      a0 = acc_n;
      bus.rsp_rdy = 1'b0;
      bus.req_vld = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         bus.req_addr = BASE + 32'h100 + 32'(4 * n);
         #1;
         if (bus.req_rdy) n++;
         cyc();
      end
      #1;
      chk("bp_accepts", 32'(acc_n - a0), 32'(DEPTH));
      chk("bp_req_rdy", 32'(bus.req_rdy), 32'd0);
      chk("bp_head_addr", bus.rsp_addr, BASE + 32'h100);
      chk("bp_head_data", bus.rsp_data, 32'd64);
      cyc();
      cyc();
      chk("bp_head_stable", bus.rsp_addr, BASE + 32'h100);
      bus.rsp_rdy = 1'b1;
      c = 0;
      while (n < 10 && c < 100) begin
         bus.req_addr = BASE + 32'h100 + 32'(4 * n);
         #1;
         if (bus.req_rdy) n++;
         cyc();
         c++;
      end
      bus.req_vld = 1'b0;
      wait_drain();
      chk("bp_pops", 32'(pop_n - p0), 32'd10);

      // session drop with three responses queued
      bus.rsp_rdy = 1'b0;
      burst(BASE + 32'h200, 3, c);
      cyc();
      cyc();
      bus.req_req = 1'b0;
      cyc();
      chk("drop_busy", 32'(busy), 32'd1);
      chk("drop_req_rdy", 32'(bus.req_rdy), 32'd0);
      bus.req_req  = 1'b1;
      bus.req_vld  = 1'b1;
      bus.req_addr = BASE + 32'h300;
      #1;
      chk("drain_no_rdy", 32'(bus.req_rdy), 32'd0);
      a0 = acc_n;
      p0 = pop_n;
      bus.rsp_rdy = 1'b1;
      k = 0;
      while (busy && k < 10) begin
         cyc();
         k++;
      end
      chk("drain_idle", 32'(busy), 32'd0);
      chk("drain_pops", 32'(pop_n - p0), 32'd3);
      chk("drain_no_accept", 32'(acc_n - a0), 32'd0);
      chk("idle_req_rdy", 32'(bus.req_rdy), 32'd0);
      cyc();
      chk("reentry_req_rdy", 32'(bus.req_rdy), 32'd1);
      cyc();
      bus.req_vld = 1'b0;
      wait_drain();

      // randomized traffic against the scoreboard
      for (int i = 0; i < 600; i++) begin
         if (!bus.req_vld) begin
            bus.req_vld  = ($urandom_range(0, 3) != 0);
            bus.req_addr = rand_addr();
         end
         if ($urandom_range(0, 39) == 0) bus.req_req = !bus.req_req;
         bus.rsp_rdy = ($urandom_range(0, 2) != 0);
         #1;
         took = bus.req_vld && bus.req_req && bus.req_rdy;
         cyc();
         if (took) bus.req_vld = 1'b0;
      end
      bus.req_vld = 1'b0;
      bus.req_req = 1'b1;
      wait_drain();
      chk("rand_err_cnt", 32'(err_cnt), 32'(mdl_err));

      // error saturation
      burst(BASE + 32'h8000, 300, c);
      wait_drain();
      chk("sat_err_cnt", 32'(err_cnt), 32'd255);

      // async reset with four queued responses
      bus.rsp_rdy = 1'b0;
      burst(BASE + 32'h400, 4, c);
      cyc();
      cyc();
      chk("pre_rst_vld", 32'(bus.rsp_vld), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
      chk("arst_req_rdy", 32'(bus.req_rdy), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      mdl_err = 0;
      bus.req_req = 1'b0;
      bus.rsp_rdy = 1'b1;
      cyc();
      cyc();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus.rsp_vld) seen = 1'b1;
         cyc();
      end
      chk("no_stale_rsp", 32'(seen), 32'd0);
      chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);
      do_read('{BASE + 32'h190, 1'b0, 32'hA5A5_0064});
      wait_drain();

      $display("%0d/%0d checks passed", pass_n, chk_n);
      $finish;
   end
endmodule
